// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV flag layout, zero-register index and datapath defaults.
package cpu_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_RADDR = 5;

  localparam logic [4:0] XZR = 5'd31;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/zero_detect64.sv
// 64-input NOR as a 16 -> 4 -> 1 tree of 4-input OR gates with a final inversion,
// mirroring the gate-level structure of the ALU.
module zero_detect64 (
  input  logic [63:0] data,
  output logic        zero
);

  logic [15:0] or_l1;
  logic [3:0]  or_l2;
  logic        any_set;

  for (genvar i = 0; i < 16; i++) begin : g_l1
    assign or_l1[i] = |data[4*i +: 4];
  end

  for (genvar j = 0; j < 4; j++) begin : g_l2
    assign or_l2[j] = |or_l1[4*j +: 4];
  end

  assign any_set = |or_l2;
  assign zero    = ~any_set;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV flag register.
// Priority on each edge: reset > flush > stall > load.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RADDR = DEF_RADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_carry,
  input  logic             ex_overflow,
  input  logic             ex_set_flags,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [RADDR-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  output logic             ex_zero,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [RADDR-1:0] mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [3:0]       flags
);

  nzcv_t flags_q;
  logic  load;
  logic  rd_is_xzr;

  zero_detect64 u_zero_detect (
    .data (ex_result),
    .zero (ex_zero)
  );

  assign load      = !flush && !stall;
  assign rd_is_xzr = (ex_rd == RADDR'(XZR));

  // Data fields are left untouched by a flush; the cleared valid bit marks them dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else if (load) begin
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (!stall) begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write & ex_valid & ~rd_is_xzr;
      mem_mem_read  <= ex_mem_read & ex_valid;
      mem_mem_write <= ex_mem_write & ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (load && ex_valid && ex_set_flags) begin
      flags_q.n <= ex_result[WIDTH-1];
      flags_q.z <= ex_zero;
      flags_q.c <= ex_carry;
      flags_q.v <= ex_overflow;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: stimulus queues hand-computed expectations,
// a monitor pops one entry per clock and compares against the DUT.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid, ex_carry, ex_overflow, ex_set_flags;
  logic [63:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_zero, mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [63:0] result;
    logic [63:0] store;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [3:0]  flags;
    logic        zero;
    logic        data_chk;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_result      (ex_result),
    .ex_carry       (ex_carry),
    .ex_overflow    (ex_overflow),
    .ex_set_flags   (ex_set_flags),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_zero        (ex_zero),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .flags          (flags)
  );

  // Upstream must never present a load and a store in the same instruction.
  always @(posedge clk) begin
    if (!reset)
      assert (!(ex_valid && ex_mem_read && ex_mem_write))
        else $error("upstream issued mem_read and mem_write together");
  end

  task automatic chk(input string tag, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, field, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "ex_zero",       64'(ex_zero),       64'(e.zero));
        chk(e.tag, "mem_valid",     64'(mem_valid),     64'(e.valid));
        chk(e.tag, "mem_reg_write", 64'(mem_reg_write), 64'(e.rw));
        chk(e.tag, "mem_mem_read",  64'(mem_mem_read),  64'(e.mr));
        chk(e.tag, "mem_mem_write", 64'(mem_mem_write), 64'(e.mw));
        chk(e.tag, "flags",         64'(flags),         64'(e.flags));
        if (e.data_chk) begin
          chk(e.tag, "mem_result",     mem_result,     e.result);
          chk(e.tag, "mem_store_data", mem_store_data, e.store);
          chk(e.tag, "mem_rd",         64'(mem_rd),    64'(e.rd));
        end
      end
    end
  end

  // Drive inputs at the falling edge; the expectation describes the DUT just after
  // the following rising edge (ex_zero refers to the inputs driven here).
  task automatic step(input string tag,
                      input logic rs, st, fl, v, input logic [63:0] res,
                      input logic c, o, sf, input logic [63:0] sd, input logic [4:0] rd,
                      input logic rw, mr, mw,
                      input logic ev, input logic [63:0] eres, esd, input logic [4:0] erd,
                      input logic erw, emr, emw, input logic [3:0] ef, input logic ez,
                      input logic edata);
    exp_t e;
    @(negedge clk);
    reset = rs; stall = st; flush = fl; ex_valid = v; ex_result = res;
    ex_carry = c; ex_overflow = o; ex_set_flags = sf; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    e.tag = tag; e.valid = ev; e.result = eres; e.store = esd; e.rd = erd;
    e.rw = erw; e.mr = emr; e.mw = emw; e.flags = ef; e.zero = ez; e.data_chk = edata;
    sb.push_back(e);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] AAAA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] S555 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] NEG  = 64'h8000_0000_0000_0000;

  initial begin
    int budget;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_result = '0;
    ex_carry = 1'b0; ex_overflow = 1'b0; ex_set_flags = 1'b0; ex_store_data = '0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;

    //    tag         rs st fl v  result   c  o  sf store  rd  rw mr mw | v  result   store  rd  rw mr mw flags  z  data
    step("reset",     1, 0, 0, 1, ONES,    1, 1, 1, ONES,  31, 1, 1, 1,  0, 64'h0,   64'h0, 0,  0, 0, 0, 4'h0, 0, 1);
    step("flagset",   0, 0, 0, 1, NEG,     1, 1, 1, 64'h1234, 3, 1, 0, 0, 1, NEG,   64'h1234, 3, 1, 0, 0, 4'hB, 0, 1);
    step("flaghold",  0, 0, 0, 1, 64'h0,   1, 1, 0, 64'h0, 4,  1, 0, 0,  1, 64'h0,   64'h0, 4,  1, 0, 0, 4'hB, 1, 1);
    step("zeroflag",  0, 0, 0, 1, 64'h0,   0, 0, 1, 64'h5, 6,  1, 1, 0,  1, 64'h0,   64'h5, 6,  1, 1, 0, 4'h4, 1, 1);
    step("nonzero",   0, 0, 0, 1, 64'h1,   0, 0, 0, 64'h99, 7, 0, 0, 1,  1, 64'h1,   64'h99, 7, 0, 0, 1, 4'h4, 0, 1);
    step("xzr",       0, 0, 0, 1, 64'h10,  0, 0, 0, 64'h0, 31, 1, 0, 0,  1, 64'h10,  64'h0, 31, 0, 0, 0, 4'h4, 0, 1);
    step("rd5",       0, 0, 0, 1, 64'h20,  0, 0, 0, 64'h0, 5,  1, 0, 0,  1, 64'h20,  64'h0, 5,  1, 0, 0, 4'h4, 0, 1);
    step("loadA",     0, 0, 0, 1, AAAA,    0, 0, 1, S555,  9,  1, 0, 0,  1, AAAA,    S555,  9,  1, 0, 0, 4'h8, 0, 1);
    step("stall1",    0, 1, 0, 1, 64'h0,   1, 0, 1, 64'h7, 10, 0, 0, 1,  1, AAAA,    S555,  9,  1, 0, 0, 4'h8, 1, 1);
    step("stall2",    0, 1, 0, 1, 64'h3,   1, 1, 1, 64'h8, 11, 0, 1, 0,  1, AAAA,    S555,  9,  1, 0, 0, 4'h8, 0, 1);
    step("stall3",    0, 1, 0, 0, 64'h0,   0, 1, 1, 64'h9, 12, 0, 0, 0,  1, AAAA,    S555,  9,  1, 0, 0, 4'h8, 1, 1);
    step("stallflush",0, 1, 1, 1, 64'h0,   1, 1, 1, 64'h0, 12, 1, 0, 0,  0, 64'h0,   64'h0, 0,  0, 0, 0, 4'h8, 1, 0);
    step("unstall",   0, 0, 0, 1, 64'h40,  0, 0, 0, 64'h1, 13, 1, 0, 0,  1, 64'h40,  64'h1, 13, 1, 0, 0, 4'h8, 0, 1);
    step("bubble",    0, 0, 0, 0, 64'h0,   1, 1, 1, 64'h2, 14, 1, 0, 1,  0, 64'h0,   64'h2, 14, 0, 0, 0, 4'h8, 1, 1);
    step("flush",     0, 0, 1, 1, ONES,    1, 1, 1, 64'h3, 15, 1, 0, 1,  0, 64'h0,   64'h0, 0,  0, 0, 0, 4'h8, 0, 0);
    step("negcarry",  0, 0, 0, 1, ONES,    1, 0, 1, 64'h4, 1,  1, 0, 0,  1, ONES,    64'h4, 1,  1, 0, 0, 4'hA, 0, 1);
    step("rststall",  1, 1, 0, 1, 64'h5,   1, 1, 1, 64'h6, 2,  1, 0, 1,  0, 64'h0,   64'h0, 0,  0, 0, 0, 4'h0, 0, 1);
    step("idle",      0, 0, 0, 0, 64'h0,   0, 0, 0, 64'h0, 0,  0, 0, 0,  0, 64'h0,   64'h0, 0,  0, 0, 0, 4'h0, 1, 1);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the pipelined 64-bit ARM CPU. Sits directly downstream of the 64-bit ALU (arithmetic, AND/OR/XOR bitwise units) and registers its result, control bits and store data for the MEM stage. It also owns the architectural NZCV flag register, updated from ALU outputs on flag-setting instructions, and supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- WIDTH, 64, datapath width
- RADDR, 5, register-index width

Ports (clock and reset are `clk`/`reset`; reset is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold all stage registers and flags
- flush  in  1  replace incoming instruction with a bubble
- ex_valid  in  1  instruction in EX is real (not a bubble)
- ex_result  in  WIDTH  ALU result
- ex_carry  in  1  ALU carry-out
- ex_overflow  in  1  ALU signed overflow
- ex_set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- ex_store_data  in  WIDTH  register value for STUR
- ex_rd  in  RADDR  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_zero  out  1  combinational: ex_result == 0 (for CBZ)
- mem_valid  out  1  registered valid
- mem_result  out  WIDTH  registered ALU result / memory address
- mem_store_data  out  WIDTH  registered store data
- mem_rd  out  RADDR  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered, qualified controls
- flags  out  4  architectural NZCV, bit3=N, bit2=Z, bit1=C, bit0=V

## Operation
- Per-edge priority: reset > flush > stall > load.
- Reset: mem_valid=0, mem_result=0, mem_store_data=0, mem_rd=0, all mem_* controls=0, flags=4'b0000.
- Flush (stall ignored): mem_valid=0, all mem_* controls=0; data fields may keep old values; flags unchanged.
- Stall (no flush): every register, including flags, holds.
- Load: mem_valid=ex_valid; data fields copied; each control = ex_ctrl & ex_valid.
- mem_reg_write forced 0 when ex_rd==31 (XZR); mem_rd still loads 31.
- mem_mem_read and mem_mem_write both 1: illegal; bench asserts it never occurs upstream; stage passes both unchanged.
- Flag update on load only, when ex_valid & ex_set_flags: N=ex_result[WIDTH-1], Z=ex_zero, C=ex_carry, V=ex_overflow. Otherwise flags hold.
- ex_zero purely combinational from ex_result; unaffected by stall/flush/reset.

## Timing
- Latency one cycle EX→MEM; flags visible the cycle after the setting instruction leaves EX, so a B.cond in EX the next cycle reads correct flags without forwarding.
- Stall held N cycles: outputs constant N cycles, then load on the first non-stall edge.
- Reset mid-stall or mid-flush: reset wins, values as above on the next edge.
- ex_zero settles within ALU delay plus zero-detect delay (≤0.25 ns); no registered path.

## Structure
- Shared package `cpu_pkg`: `nzcv_t` packed struct {n,z,c,v}, flag bit-index constants, `XZR = 5'd31`, `WIDTH` default.
- One sub-module: `zero_detect64` — 64-input NOR built as a tree of 4-input gate primitives (16→4→1, final inversion), 50 ps per gate, matching the ALU gate-level style.
- Registers: one always_ff per field group (data, control, flags); no FSM beyond the valid bit.

## Test plan
- Reset: drive reset 1 cycle with ex_* = all ones → all mem_* = 0, flags = 0000, mem_valid = 0.
- Flag set: ex_result=64'h8000_0000_0000_0000, ex_carry=1, ex_overflow=1, ex_set_flags=1, ex_valid=1 → next cycle flags=1011, mem_result matches; then ex_result=0, ex_set_flags=0 → ex_zero=1, flags stay 1011.
- Zero flag: ex_result=0, ex_set_flags=1, carry=overflow=0 → flags=0100; ex_result=64'h1 → ex_zero=0.
- XZR: ex_rd=31, ex_reg_write=1, ex_valid=1 → mem_rd=31, mem_reg_write=0; ex_rd=5 → mem_reg_write=1.
- Stall/flush: load result 64'hAAAA…, stall 3 cycles with new inputs → mem_result holds 64'hAAAA…; assert stall+flush with ex_set_flags=1 → mem_valid=0, controls 0, flags unchanged.
- Bubble: ex_valid=0 with ex_mem_write=1, ex_set_flags=1 → mem_mem_write=0, flags unchanged.
